// File: rtl/tpu_host_pkg.sv
// Shared types for the host-side TPU pin driver.
// Widths, FSM states and the command FIFO entry layout.
package tpu_host_pkg;

    localparam int INSTR_W  = 16;
    localparam int RESULT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic               capture;
        logic [INSTR_W-1:0] word;
    } cmd_entry_t;

endpackage

// File: rtl/tpu_instr_driver_if.sv
// Host command/response streams plus the TPU pin bundle.
// master = host/TPU side, slave = the driver.
interface tpu_instr_driver_if;
    import tpu_host_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [INSTR_W-1:0]  cmd_word;
    logic                cmd_capture;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [RESULT_W-1:0] rsp_data;
    logic [INSTR_W-1:0]  tpu_instr;
    logic [RESULT_W-1:0] tpu_result;

    modport master (
        output cmd_valid, cmd_word, cmd_capture, rsp_ready, tpu_result,
        input  cmd_ready, rsp_valid, rsp_data, tpu_instr
    );

    modport slave (
        input  cmd_valid, cmd_word, cmd_capture, rsp_ready, tpu_result,
        output cmd_ready, rsp_valid, rsp_data, tpu_instr
    );

endinterface

// File: rtl/tpu_instr_driver_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Storage is cleared on reset so the head reads zero when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          wr;
    logic          rd;

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem[rptr];

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        cnt_nxt = cnt;
        case ({wr, rd})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointers, storage and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/tpu_instr_driver.sv
// Buffers host instructions onto the TPU pins, one per cycle,
// and returns result-pin samples for flagged instructions.
module tpu_instr_driver
    import tpu_host_pkg::*;
#(
    parameter int                 CMD_DEPTH  = 8,
    parameter int                 RSP_DEPTH  = 8,
    parameter int                 RESULT_LAT = 2,
    parameter logic [INSTR_W-1:0] IDLE_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        busy,
    output logic [15:0] issued_count,
    tpu_instr_driver_if.slave bus
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    cmd_entry_t          cmd_in;
    cmd_entry_t          cmd_head;
    logic                cmd_full;
    logic                cmd_empty;
    logic                cmd_push;
    logic                rsp_full;
    logic                rsp_empty;
    logic                rsp_push;
    logic                rsp_pop;
    logic                issue;
    logic                cap_issue;
    logic                pipe_empty;
    logic [CW-1:0]       credits;
    logic [RESULT_LAT:0] pipe;
    logic [INSTR_W-1:0]  instr_q;
    state_t              state_q;
    state_t              state_d;

    assign cmd_in.capture = bus.cmd_capture;
    assign cmd_in.word    = bus.cmd_word;
    assign cmd_push       = bus.cmd_valid && !cmd_full;
    assign bus.cmd_ready  = !cmd_full;

    // A capture may only issue once its result slot is reserved
    assign issue = run && !cmd_empty
                && (!cmd_head.capture || credits != '0);
    assign cap_issue  = issue && cmd_head.capture;
    assign pipe_empty = ~|pipe;

    // Top pipe bit marks the edge ending cycle N+RESULT_LAT
    assign rsp_push      = pipe[RESULT_LAT];
    assign rsp_pop       = bus.rsp_ready && !rsp_empty;
    assign bus.rsp_valid = !rsp_empty;
    assign bus.tpu_instr = instr_q;

    assign busy = (state_q != IDLE) || !cmd_empty || !rsp_empty;

    sync_fifo #(
        .W     ($bits(cmd_entry_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (issue),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(
        .W     (RESULT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .wdata (bus.tpu_result),
        .pop   (rsp_pop),
        .rdata (bus.rsp_data),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    // Instruction pins, issue counter, capture pipe and credits
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q      <= IDLE_WORD;
            issued_count <= '0;
            pipe         <= '0;
            credits      <= CW'(RSP_DEPTH);
        end else begin
            instr_q <= issue ? cmd_head.word : IDLE_WORD;
            if (issue) begin
                issued_count <= issued_count + 16'd1;
            end
            pipe <= {pipe[RESULT_LAT-1:0], cap_issue};
            case ({cap_issue, rsp_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) state_d = ISSUE;
            end
            ISSUE: begin
                if (!issue) state_d = pipe_empty ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (issue)           state_d = ISSUE;
                else if (pipe_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credits must keep the result FIFO from ever overflowing
    a_no_rsp_overflow: assert property (
        @(posedge clk) disable iff (rst) !(rsp_push && rsp_full)
    );

endmodule

// File: tb/tb_tpu_instr_driver.sv
// Bench for tpu_instr_driver: scoreboard of instruction words
// and responses, with a TPU model echoing the delayed low byte.
module tb_tpu_instr_driver;
    import tpu_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        busy;
    logic [15:0] issued_count;

    tpu_instr_driver_if bus();

    tpu_instr_driver #(
        .CMD_DEPTH  (8),
        .RSP_DEPTH  (8),
        .RESULT_LAT (2),
        .IDLE_WORD  (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .busy         (busy),
        .issued_count (issued_count),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [15:0] d1  = '0;
    logic [15:0] d2  = '0;
    bit          lat_mode = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= bus.tpu_instr;
        d2  <= d1;
    end

    // TPU model: result pins carry the instruction from 2 cycles ago,
    // or a per-cycle pattern when checking capture timing
    assign bus.tpu_result = lat_mode ? (8'(cyc) ^ 8'h5A) : d2[7:0];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt = 0;
    logic [7:0]  rsp_q[$];
    logic [15:0] ins_q[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Monitor: instruction pins and response stream vs scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (lat_mode && bus.tpu_instr == 16'hC0DE) begin
                rsp_q.push_back(8'(cyc + 2) ^ 8'h5A);
            end
            if (bus.tpu_instr !== 16'h0000) begin
                if (ins_q.size() == 0) note_fail("instr_unexpected");
                else check("instr", bus.tpu_instr, ins_q.pop_front());
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) note_fail("rsp_unexpected");
                else check("rsp", bus.rsp_data, rsp_q.pop_front());
            end
        end
    end

    task automatic push_cmd(input logic [15:0] w, input logic cap);
        logic ok;
        bus.cmd_word    = w;
        bus.cmd_capture = cap;
        bus.cmd_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        bus.cmd_valid = 1'b0;
        note_fail("push_timeout");
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && rsp_q.size() == 0 && ins_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        note_fail(nm);
    endtask

    task automatic wait_word(input logic [15:0] w, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tpu_instr == w) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit seen;
        bus.cmd_valid   = 1'b0;
        bus.cmd_word    = '0;
        bus.cmd_capture = 1'b0;
        bus.rsp_ready   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr", bus.tpu_instr, 16'h0000);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_count", issued_count, 16'h0000);
        rst = 1'b0;

        // Reset with three queued commands discards them
        push_cmd(16'h0A01, 1'b1);
        push_cmd(16'h0A02, 1'b1);
        push_cmd(16'h0A03, 1'b1);
        check("queued_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_instr", bus.tpu_instr, 16'h0000);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_count", issued_count, 16'h0000);
        check("mid_rst_busy", busy, 0);
        bus.rsp_ready = 1'b1;
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_count", issued_count, 16'h0000);

        // Stream of three words, two captured
        ins_q.push_back(16'h1234);
        ins_q.push_back(16'hABCD);
        ins_q.push_back(16'h00FF);
        rsp_q.push_back(8'h34);
        rsp_q.push_back(8'hFF);
        exp_cnt += 3;
        fork
            begin
                push_cmd(16'h1234, 1'b1);
                push_cmd(16'hABCD, 1'b0);
                push_cmd(16'h00FF, 1'b1);
            end
            begin
                wait_word(16'h1234, seen);
                if (!seen) begin
                    note_fail("stream_first_word");
                end else begin
                    @(negedge clk);
                    check("stream_w1", bus.tpu_instr, 16'hABCD);
                    @(negedge clk);
                    check("stream_w2", bus.tpu_instr, 16'h00FF);
                    @(negedge clk);
                    check("stream_idle", bus.tpu_instr, 16'h0000);
                end
            end
        join
        wait_idle("stream_drain");
        check("stream_count", issued_count, 16'(exp_cnt));

        // Capture timing against a per-cycle result pattern
        lat_mode = 1'b1;
        ins_q.push_back(16'hC0DE);
        exp_cnt += 1;
        push_cmd(16'hC0DE, 1'b1);
        wait_idle("latency_drain");
        lat_mode = 1'b0;
        check("latency_count", issued_count, 16'(exp_cnt));

        // Response backpressure: credits stop issue after 8 captures
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ins_q.push_back(16'h0110 + 16'(i));
            rsp_q.push_back(8'h10 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            push_cmd(16'h0110 + 16'(i), 1'b1);
        end
        repeat (20) @(posedge clk);
        #1;
        check("bp_issued", issued_count, 16'(exp_cnt + 8));
        check("bp_instr_idle", bus.tpu_instr, 16'h0000);
        check("bp_state", (dut.state_q == DRAIN || dut.state_q == IDLE), 1);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        check("bp_pending", ins_q.size(), 2);
        bus.rsp_ready = 1'b1;
        exp_cnt += 10;
        wait_idle("bp_drain");
        check("bp_count", issued_count, 16'(exp_cnt));

        // Command FIFO full with issue held off
        run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_cmd(16'h2200 + 16'(i), 1'b0);
        end
        check("full_ready", bus.cmd_ready, 0);
        bus.cmd_word    = 16'hDEAD;
        bus.cmd_capture = 1'b0;
        bus.cmd_valid   = 1'b1;
        @(negedge clk);
        check("full_refuse", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ins_q.push_back(16'h2200 + 16'(i));
        end
        exp_cnt += 8;
        run = 1'b1;
        wait_idle("full_drain");
        check("full_count", issued_count, 16'(exp_cnt));
        check("full_ready_after", bus.cmd_ready, 1);

        // Counter wrap through NOP issues
        for (int i = exp_cnt; i < 65535; i++) begin
            push_cmd(16'h0000, 1'b0);
        end
        exp_cnt = 65535;
        wait_idle("wrap_fill");
        check("wrap_ffff", issued_count, 16'hFFFF);
        ins_q.push_back(16'h7777);
        push_cmd(16'h7777, 1'b0);
        wait_idle("wrap_last");
        check("wrap_zero", issued_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
